serial_capture: RTL

SERIAL_CAPTURE -- requirements
Module: serial_capture

---
 rtl/serial_capture_pkg.sv | 14 +
 rtl/serial_capture_bit_counter.sv | 29 ++
 rtl/serial_capture.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_capture_pkg.sv
// Shared types and limits for the serial_capture block: FSM state encoding
// and the legal word-width range.
package serial_capture_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_capture_bit_counter.sv
// Modulo-MAX bit counter with synchronous clear and enable; o_tc flags the
// final count so the caller knows the next enabled bit completes a word.
module bit_counter #(
    parameter int MAX = 5,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [W-1:0] r_count;

    assign o_tc = (r_count == W'(MAX - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            // Wraps straight to zero on the last bit, so it never reaches MAX.
            r_count <= o_tc ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_capture.sv
// Serial-to-parallel word capture: start-triggered shifting of DEPTH valid
// bits, then a held output word released by out_ready, with a sticky overrun.
module serial_capture
    import serial_capture_pkg::*;
#(
    parameter int DEPTH     = 5,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic [DEPTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("serial_capture: DEPTH out of legal range");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [DEPTH-1:0] r_shift;
    logic [DEPTH-1:0] r_out;
    logic [DEPTH-1:0] w_shift_next;
    logic             r_overrun;
    logic             w_restart;
    logic             w_accept;
    logic             w_drop;
    logic             w_tc;

    // start wins over sin_valid; in HOLD it only restarts when the word is taken.
    assign w_restart = start && ((r_state == IDLE) || (r_state == SHIFT) ||
                                 ((r_state == HOLD) && out_ready));
    assign w_accept  = (r_state == SHIFT) && !start && sin_valid;
    assign w_drop    = (r_state == HOLD) && start && !out_ready;

    if (LSB_FIRST) begin : g_lsb_first
        assign w_shift_next = {sin, r_shift[DEPTH-1:1]};
    end else begin : g_msb_first
        assign w_shift_next = {r_shift[DEPTH-2:0], sin};
    end

    bit_counter #(
        .MAX (DEPTH)
    ) u_bit_counter (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (w_restart),
        .i_en    (w_accept),
        .o_tc    (w_tc)
    );

    always_comb begin
        // NOTE: assigning the default before the case keeps every path covered, so no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SHIFT;
            SHIFT:   if (w_accept && w_tc) w_next_state = HOLD;
            HOLD:    if (out_ready) w_next_state = start ? SHIFT : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register update from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the data registers are reset too, because out must read 0 after reset, not stale data.
            r_state   <= IDLE;
            r_shift   <= '0;
            r_out     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_restart) begin
                r_shift <= '0;
            end else if (w_accept) begin
                r_shift <= w_shift_next;
            end
            if (w_accept && w_tc) begin
                r_out <= w_shift_next;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state == SHIFT);
    assign overrun   = r_overrun;

endmodule
